// File: rtl/fu_decode_stage.sv
// fu_decode_stage: RV32IM decode register with valid/ready handshake and per-unit credit throttling
module fu_decode_stage #(
   parameter int TAG_W       = 6,
   parameter int ALU_CREDITS = 4,
   parameter int MUL_CREDITS = 2,
   parameter int DIV_CREDITS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [1:0]       alu_op,
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       out_alu_ctrl,
   output logic [1:0]       out_fu_type,
   output logic [2:0]       out_branch_type,
   output logic             out_illegal,
   input  logic             credit_ret_alu,
   input  logic             credit_ret_mul,
   input  logic             credit_ret_div
);
   localparam logic [3:0] ALU_MAX = 4'(ALU_CREDITS);
   localparam logic [3:0] MUL_MAX = 4'(MUL_CREDITS);
   localparam logic [3:0] DIV_MAX = 4'(DIV_CREDITS);

   logic             r_held;
   logic [TAG_W-1:0] r_tag;
   logic [3:0]       r_ctrl;
   logic [1:0]       r_fu;
   logic [2:0]       r_br;
   logic             r_ill;
   logic [3:0]       r_cred_alu, r_cred_mul, r_cred_div;
   logic [3:0]       w_ctrl;
   logic [1:0]       w_fu;
   logic [2:0]       w_br;
   logic             w_ill, w_cred_ok, w_fire, w_accept;

   // consume and return together cancel; a return at the maximum is dropped
   function automatic logic [3:0] f_cred(input logic [3:0] c, input logic [3:0] max,
                                         input logic use_c, input logic ret);
      return (use_c && !ret) ? c - 4'd1 : (ret && !use_c && c != max) ? c + 4'd1 : c;
   endfunction

   always_comb begin
      w_ill  = 1'b0;
      w_fu   = 2'd0;
      w_ctrl = 4'd0;
      w_br   = 3'd0;
      if (alu_op == 2'b11) begin
         w_fu = 2'd1;
      end else if (alu_op == 2'b01) begin
         w_fu   = 2'd1;
         w_ctrl = 4'd1;
         w_ill  = funct3[2:1] == 2'b01;
         w_br   = funct3[2] ? funct3 - 3'd1 : {2'b00, funct3[0]} + 3'd1;
      end else if (alu_op == 2'b10) begin
         if (funct7 == 7'h00) begin
            w_fu = 2'd1;
            case (funct3)
               3'd0:    w_ctrl = 4'd0;
               3'd1:    w_ctrl = 4'd2;
               3'd2:    w_ctrl = 4'd3;
               3'd3:    w_ctrl = 4'd4;
               3'd4:    w_ctrl = 4'd5;
               3'd5:    w_ctrl = 4'd6;
               3'd6:    w_ctrl = 4'd8;
               default: w_ctrl = 4'd9;
            endcase
         end else if (funct7 == 7'h20) begin
            w_fu   = 2'd1;
            w_ctrl = funct3 == 3'd5 ? 4'd7 : 4'd1;
            w_ill  = funct3 != 3'd0 && funct3 != 3'd5;
         end else if (funct7 == 7'h01) begin
            w_fu   = funct3[2] ? 2'd3 : 2'd2;
            w_ctrl = {2'b00, funct3[1:0]};
         end else begin
            w_ill = 1'b1;
         end
      end
      if (w_ill) begin
         w_fu   = 2'd0;
         w_ctrl = 4'd0;
         w_br   = 3'd0;
      end
   end

   assign w_cred_ok = r_fu == 2'd1 ? r_cred_alu != 4'd0 :
                      r_fu == 2'd2 ? r_cred_mul != 4'd0 :
                      r_fu == 2'd3 ? r_cred_div != 4'd0 : 1'b1;
   assign out_valid = !rst && r_held && w_cred_ok;
   assign w_fire    = out_valid && out_ready;
   assign in_ready  = !rst && !flush && (!r_held || w_fire);
   assign w_accept  = in_valid && in_ready;

   assign out_tag         = r_tag;
   assign out_alu_ctrl    = r_ctrl;
   assign out_fu_type     = r_fu;
   assign out_branch_type = r_br;
   assign out_illegal     = r_ill;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_held     <= 1'b0;
         r_tag      <= '0;
         r_ctrl     <= 4'd0;
         r_fu       <= 2'd0;
         r_br       <= 3'd0;
         r_ill      <= 1'b0;
         r_cred_alu <= ALU_MAX;
         r_cred_mul <= MUL_MAX;
         r_cred_div <= DIV_MAX;
      end else begin
         if (w_accept) begin
            r_held <= 1'b1;
            r_tag  <= in_tag;
            r_ctrl <= w_ctrl;
            r_fu   <= w_fu;
            r_br   <= w_br;
            r_ill  <= w_ill;
         end else if (w_fire || flush) begin
            r_held <= 1'b0;
         end
         r_cred_alu <= f_cred(r_cred_alu, ALU_MAX, w_fire && r_fu == 2'd1, credit_ret_alu);
         r_cred_mul <= f_cred(r_cred_mul, MUL_MAX, w_fire && r_fu == 2'd2, credit_ret_mul);
         r_cred_div <= f_cred(r_cred_div, DIV_MAX, w_fire && r_fu == 2'd3, credit_ret_div);
      end
   end
endmodule

// File: doc/fu_decode_stage.md
# fu_decode_stage

Registered decode-and-dispatch stage for the out-of-order core. It decodes `alu_op`/`funct3`/`funct7` into the full RV32IM function-unit control set: all R-type ALU ops, all six branches, and all eight M-extension ops. It holds the decoded micro-op in an output register with a valid/ready handshake. Per-unit credit counters throttle dispatch to the ALU, MUL and DIV reservation stations, so a micro-op leaves only when its unit has a free slot.

## Interface
Parameters:
- `TAG_W`, 6, width of the ROB tag carried with each micro-op
- `ALU_CREDITS`, 4, ALU reservation-station slots (1..15)
- `MUL_CREDITS`, 2, MUL slots (1..15)
- `DIV_CREDITS`, 1, DIV slots (1..15)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  squash the held micro-op (branch mispredict)
- `in_valid`  in  1  upstream has an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_tag`  in  TAG_W  ROB tag
- `alu_op`  in  2  from main control: 00 none, 01 branch, 10 R-type, 11 load/store/jal
- `funct3`  in  3  instr[14:12]
- `funct7`  in  7  instr[31:25]
- `out_valid`  out  1  held micro-op may dispatch
- `out_ready`  in  1  downstream accepts
- `out_tag`  out  TAG_W  held tag
- `out_alu_ctrl`  out  4  op within the selected unit
- `out_fu_type`  out  2  0 none, 1 ALU, 2 MUL, 3 DIV
- `out_branch_type`  out  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU
- `out_illegal`  out  1  undefined encoding
- `credit_ret_alu`, `credit_ret_mul`, `credit_ret_div`  in  1 each  one-cycle pulse: one slot freed in that unit

## Operation
- ALU ctrl codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
- MUL ctrl codes: MUL 0, MULH 1, MULHSU 2, MULHU 3.
- DIV ctrl codes: DIV 0, DIVU 1, REM 2, REMU 3.
- `alu_op`=11: ALU, ADD, branch 0.
- `alu_op`=01: ALU, SUB; branch type from funct3: 000→1, 001→2, 100→3, 101→4, 110→5, 111→6. funct3 010/011 is illegal.
- `alu_op`=10, funct7=0000000: ALU; funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- `alu_op`=10, funct7=0100000: ALU; funct3 000 SUB, 101 SRA; any other funct3 is illegal.
- `alu_op`=10, funct7=0000001: funct3[2]=0 selects MUL, funct3[2]=1 selects DIV; ctrl = funct3[1:0].
- `alu_op`=10, any other funct7: illegal.
- `alu_op`=00: fu_type 0, not illegal. It passes through for ROB bookkeeping.
- Illegal encodings force fu_type 0, ctrl 0, branch 0, illegal 1.
- State is `held`, the payload register, and three credit counters `cred_X` of 4 bits each.
- `out_valid` = `held` && (fu_type==0 || `cred_X`>0 for the held unit).
- Handshake `fire` = `out_valid` && `out_ready`.
- `in_ready` = !`flush` && (!`held` || `fire`). It does not depend on the `in_*` inputs.
- Accepting an input (`in_valid` && `in_ready`) loads the decoded payload and sets `held`.
- `fire` without a new accept clears `held`.
- `cred_X` next value = `cred_X` − (fire to X) + `credit_ret_X`.
  - Consume and return in the same cycle leave the count unchanged.
  - A return while `cred_X` equals its maximum is ignored; the count saturates.
  - A fire while `cred_X`=0 is impossible by construction.
- fu_type 0 micro-ops (none or illegal) never consume credits.
- `flush` clears `held` next edge and blocks acceptance that cycle. A fire in the flush cycle still counts and still consumes its credit. Credit returns during flush are applied.

## Timing
- Reset: `held`=0, all payload outputs 0, `out_valid`=0, `in_ready`=0 during the reset cycle, `cred_X`=X_CREDITS.
  - Reset mid-stream discards the held micro-op and reloads all credits, regardless of outstanding slots.
  - `in_ready` goes high the cycle after `rst` deasserts.
- Latency: accepted at edge N, `out_valid` rises after edge N if a credit is available.
- Throughput: one micro-op per cycle when `out_ready`=1 and credits are available. Back-to-back accept and fire occur in the same cycle.
- Stability: once `out_valid` is high, it and the payload stay constant until `fire` or `flush`, since credits only drop on fire.
- A credit return pulse at edge N can release a stalled micro-op in cycle N+1.

## Test plan
- Decode sweep, all 2×8×(3 funct7 classes + 1 other) combinations at `out_ready`=1. Check every code against the table above, e.g. 10/101/0100000 → ALU SRA (7); 10/011/0000001 → MUL MULHU (3); 01/010 → illegal=1, fu 0.
- Credit exhaustion: DIV_CREDITS=1. Send two DIVs with no return: first fires, second holds with `out_valid`=0 and `in_ready`=0. Pulse `credit_ret_div` → second fires the next cycle.
- Simultaneous consume and return: MUL credit at 1, fire MUL with `credit_ret_mul` in the same cycle → count stays 1. Extra return at max → stays at MUL_CREDITS.
- Backpressure: `out_ready`=0 for 5 cycles with an ALU op held → payload stable, `in_ready`=0. Release → 4 back-to-back ops each fire in consecutive cycles.
- Flush: hold a MUL, assert `flush` with `in_valid`=1 → next cycle `held`=0, no credit consumed, the input is not accepted.
- Reset mid-op: consume 3 ALU credits, assert `rst` → `out_valid`=0 and `cred_alu`=4. The next 4 ALU ops fire without any returns.
